// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key-schedule types, sizes and RCON lookup
package aes_pkg;

    localparam int NR     = 10;
    localparam int KEY_W  = 128;
    localparam int RIDX_W = 4;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } ks_state_t;

    // RCON for rounds 1..NR, first entry in the top byte
    localparam logic [8*NR-1:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

    function automatic byte_t rcon_of(input logic [RIDX_W-1:0] idx);
        int i;
        i = int'(idx);
        if (i < NR) begin
            rcon_of = RCON_TABLE[8*(NR-1-i) +: 8];
        end else begin
            rcon_of = 8'h00;
        end
    endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// rtl/aes_key_sched_ctrl_if.sv - key load and round-key read port bundle
interface aes_key_sched_ctrl_if;
    import aes_pkg::*;

    logic              key_valid;
    logic              key_ready;
    logic [KEY_W-1:0]  cipher_key;
    logic              rk_req;
    logic [RIDX_W-1:0] rk_round;
    logic              rk_gnt;
    logic              rk_valid;
    logic [KEY_W-1:0]  rk_out;
    logic              rk_err;
    logic              keys_ready;
    logic              busy;

    modport master (
        output key_valid, cipher_key, rk_req, rk_round,
        input  key_ready, rk_gnt, rk_valid, rk_out, rk_err, keys_ready, busy
    );

    modport slave (
        input  key_valid, cipher_key, rk_req, rk_round,
        output key_ready, rk_gnt, rk_valid, rk_out, rk_err, keys_ready, busy
    );

endinterface

// File: rtl/aes_key_round.sv
// rtl/aes_key_round.sv - one combinational AES-128 key-expansion round
module aes_key_round
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] key_i,
    input  byte_t            rcon_i,
    output logic [KEY_W-1:0] key_o
);

    word_t w0, w1, w2, w3;
    word_t rot_w, sub_w, t_w;
    word_t n0, n1, n2, n3;

    assign w0 = key_i[127:96];
    assign w1 = key_i[95:64];
    assign w2 = key_i[63:32];
    assign w3 = key_i[31:0];

    assign rot_w = {w3[23:0], w3[31:24]};

    sub_word u_sub_word (
        .word_i (rot_w),
        .word_o (sub_w)
    );

    assign t_w = sub_w ^ {rcon_i, 24'h0};
    assign n0  = w0 ^ t_w;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;

    assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/sub_word.sv
// rtl/sub_word.sv - AES S-box applied to each byte of a 32-bit word
module sub_word
    import aes_pkg::*;
(
    input  word_t word_i,
    output word_t word_o
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0x00 sits in the top byte of the table
    function automatic byte_t sbox(input byte_t b);
        int i;
        i = int'(b);
        sbox = SBOX[8*(255-i) +: 8];
    endfunction

    assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                     sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - AES-128 round-key expansion FSM, key store and read port
module aes_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    aes_key_sched_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_EXPAND = EXPAND;
    localparam logic [1:0] ST_READY  = READY;

    localparam logic [RIDX_W-1:0] NR_IDX = RIDX_W'(NR);

    logic [1:0]        state_q, state_d;
    logic [RIDX_W-1:0] rcnt_q, rcnt_d;
    logic [KEY_W-1:0]  store_q [NR+1];

    logic              rk_valid_q, rk_valid_d;
    logic              rk_err_q, rk_err_d;
    logic [KEY_W-1:0]  rk_out_q, rk_out_d;

    logic              key_accept;
    logic              load_en;
    logic              expand_en;
    logic              gnt;
    logic              round_bad;
    logic [RIDX_W-1:0] prev_idx;
    logic [RIDX_W-1:0] rd_idx;
    logic [KEY_W-1:0]  round_key;

    assign bus.key_ready  = (state_q != ST_EXPAND);
    assign bus.busy       = (state_q == ST_EXPAND);
    assign bus.keys_ready = (state_q == ST_READY);

    assign key_accept = bus.key_valid & bus.key_ready;
    // A key load wins over a same-cycle read; the requester keeps rk_req up
    assign gnt        = bus.rk_req & bus.keys_ready & ~key_accept;
    assign bus.rk_gnt = gnt;

    assign prev_idx = (rcnt_q == '0) ? '0 : rcnt_q - 1'b1;

    aes_key_round u_key_round (
        .key_i  (store_q[prev_idx]),
        .rcon_i (rcon_of(prev_idx)),
        .key_o  (round_key)
    );

    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        load_en   = 1'b0;
        expand_en = 1'b0;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (key_accept) begin
                    load_en = 1'b1;
                    rcnt_d  = 4'd1;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                expand_en = 1'b1;
                // Counter parks at NR so it never points back at round 0
                if (rcnt_q >= NR_IDX) begin
                    rcnt_d  = NR_IDX;
                    state_d = ST_READY;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            if (load_en) begin
                store_q[0] <= bus.cipher_key;
            end
            if (expand_en) begin
                store_q[rcnt_q] <= round_key;
            end
        end
    end

    assign round_bad = (bus.rk_round > NR_IDX);
    assign rd_idx    = round_bad ? '0 : bus.rk_round;

    always_comb begin
        rk_valid_d = gnt;
        rk_err_d   = gnt & round_bad;
        rk_out_d   = rk_out_q;
        if (gnt) begin
            rk_out_d = round_bad ? '0 : store_q[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_valid_q <= 1'b0;
            rk_err_q   <= 1'b0;
            rk_out_q   <= '0;
        end else begin
            rk_valid_q <= rk_valid_d;
            rk_err_q   <= rk_err_d;
            rk_out_q   <= rk_out_d;
        end
    end

    assign bus.rk_valid = rk_valid_q;
    assign bus.rk_err   = rk_err_q;
    assign bus.rk_out   = rk_out_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - directed self-checking bench for aes_key_sched_ctrl
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cnt;
    int   pulses;
    logic seen_valid;

    aes_key_sched_ctrl_if bus ();

    aes_key_sched_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " key_ready"},  128'(bus.key_ready),  128'd1);
        chk({tag, " rk_gnt"},     128'(bus.rk_gnt),     128'd0);
        chk({tag, " rk_valid"},   128'(bus.rk_valid),   128'd0);
        chk({tag, " rk_out"},     bus.rk_out,           128'd0);
        chk({tag, " rk_err"},     128'(bus.rk_err),     128'd0);
        chk({tag, " keys_ready"}, 128'(bus.keys_ready), 128'd0);
        chk({tag, " busy"},       128'(bus.busy),       128'd0);
    endtask

    task automatic read_round(input logic [3:0] r);
        bus.rk_req   = 1'b1;
        bus.rk_round = r;
        #1;
        chk($sformatf("gnt r%0d", r), 128'(bus.rk_gnt), 128'd1);
        step();
        chk($sformatf("valid r%0d", r), 128'(bus.rk_valid), 128'd1);
        pulses += int'(bus.rk_valid);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.key_valid  = 1'b0;
        bus.cipher_key = '0;
        bus.rk_req     = 1'b0;
        bus.rk_round   = '0;

        step();
        step();
        chk_reset_outputs("reset");

        // First key: FIPS-197 example
        rst_n          = 1'b1;
        bus.key_valid  = 1'b1;
        bus.cipher_key = K1;
        #1;
        chk("idle key_ready", 128'(bus.key_ready), 128'd1);
        step();
        bus.key_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("exp busy %0d", i), 128'(bus.busy), 128'd1);
            chk($sformatf("exp keys_ready %0d", i), 128'(bus.keys_ready), 128'd0);
            if (i == 3) begin
                bus.key_valid  = 1'b1;
                bus.cipher_key = K2;
                bus.rk_req     = 1'b1;
                bus.rk_round   = 4'd0;
                #1;
                chk("exp key_ready", 128'(bus.key_ready), 128'd0);
                chk("exp no gnt", 128'(bus.rk_gnt), 128'd0);
            end
            step();
            if (i == 3) begin
                bus.key_valid = 1'b0;
                bus.rk_req    = 1'b0;
                chk("exp no valid", 128'(bus.rk_valid), 128'd0);
            end
        end
        chk("ready keys_ready", 128'(bus.keys_ready), 128'd1);
        chk("ready busy", 128'(bus.busy), 128'd0);
        chk("ready key_ready", 128'(bus.key_ready), 128'd1);

        // Forward reads, back-to-back
        pulses = 0;
        for (int r = 0; r <= 10; r++) begin
            read_round(4'(r));
            chk($sformatf("fwd err r%0d", r), 128'(bus.rk_err), 128'd0);
            if (r == 0)  chk("fwd r0",  bus.rk_out, K1);
            if (r == 1)  chk("fwd r1",  bus.rk_out, K1_R1);
            if (r == 10) chk("fwd r10", bus.rk_out, K1_R10);
        end
        bus.rk_req = 1'b0;
        step();
        chk("fwd idle valid", 128'(bus.rk_valid), 128'd0);

        // Reverse reads, back-to-back
        pulses = 0;
        for (int r = 10; r >= 0; r--) begin
            read_round(4'(r));
            if (r == 10) chk("rev r10", bus.rk_out, K1_R10);
            if (r == 1)  chk("rev r1",  bus.rk_out, K1_R1);
            if (r == 0)  chk("rev r0",  bus.rk_out, K1);
        end
        chk("rev pulses", 128'(pulses), 128'd11);

        // Out-of-range indices interleaved with legal reads
        read_round(4'd11);
        chk("err11 err", 128'(bus.rk_err), 128'd1);
        chk("err11 out", bus.rk_out, 128'd0);
        read_round(4'd1);
        chk("mid r1 err", 128'(bus.rk_err), 128'd0);
        chk("mid r1", bus.rk_out, K1_R1);
        read_round(4'd15);
        chk("err15 err", 128'(bus.rk_err), 128'd1);
        chk("err15 out", bus.rk_out, 128'd0);
        read_round(4'd10);
        chk("mid r10 err", 128'(bus.rk_err), 128'd0);
        chk("mid r10", bus.rk_out, K1_R10);
        bus.rk_req = 1'b0;
        step();

        // New key in READY with a simultaneous request
        bus.key_valid  = 1'b1;
        bus.cipher_key = K2;
        bus.rk_req     = 1'b1;
        bus.rk_round   = 4'd10;
        #1;
        chk("reload key_ready", 128'(bus.key_ready), 128'd1);
        chk("reload no gnt", 128'(bus.rk_gnt), 128'd0);
        step();
        bus.key_valid = 1'b0;
        chk("reload keys_ready drop", 128'(bus.keys_ready), 128'd0);
        chk("reload no valid", 128'(bus.rk_valid), 128'd0);
        chk("reload busy", 128'(bus.busy), 128'd1);
        cnt        = 0;
        seen_valid = 1'b0;
        while (!bus.keys_ready && cnt < 20) begin
            step();
            cnt++;
            seen_valid = seen_valid | bus.rk_valid;
        end
        chk("reload latency", 128'(cnt), 128'd10);
        chk("reload valid during expand", 128'(seen_valid), 128'd0);
        #1;
        chk("reload held gnt", 128'(bus.rk_gnt), 128'd1);
        step();
        chk("reload valid", 128'(bus.rk_valid), 128'd1);
        chk("reload r10", bus.rk_out, K2_R10);
        bus.rk_req = 1'b0;
        step();

        // Reset in the middle of an expansion
        bus.key_valid  = 1'b1;
        bus.cipher_key = K1;
        step();
        bus.key_valid = 1'b0;
        repeat (5) step();
        chk("pre-abort busy", 128'(bus.busy), 128'd1);
        bus.rk_req   = 1'b1;
        bus.rk_round = 4'd0;
        rst_n        = 1'b0;
        #1;
        chk_reset_outputs("abort");
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post-rst gnt %0d", i), 128'(bus.rk_gnt), 128'd0);
            chk($sformatf("post-rst valid %0d", i), 128'(bus.rk_valid), 128'd0);
        end
        bus.key_valid  = 1'b1;
        bus.cipher_key = K2;
        #1;
        chk("post-rst load no gnt", 128'(bus.rk_gnt), 128'd0);
        step();
        bus.key_valid = 1'b0;
        cnt        = 0;
        seen_valid = 1'b0;
        while (!bus.keys_ready && cnt < 20) begin
            chk($sformatf("post-rst expand gnt %0d", cnt), 128'(bus.rk_gnt), 128'd0);
            step();
            cnt++;
            seen_valid = seen_valid | bus.rk_valid;
        end
        chk("post-rst latency", 128'(cnt), 128'd10);
        chk("post-rst no early valid", 128'(seen_valid), 128'd0);
        pulses = 0;
        read_round(4'd0);
        chk("post-rst r0", bus.rk_out, K2);
        read_round(4'd10);
        chk("post-rst r10", bus.rk_out, K2_R10);
        bus.rk_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
